aes_iter_cipher_core: RTL and testbench

//  Iterative AES core that runs one full round per clock, with encrypt or decrypt selected per block.
//  It generalises the round-driven decipher datapath: the round counter, FSM and valid/ready handshakes
//  are internal, and key size is a parameter (AES-128/192/256).
//  It sits between the key-expansion block, which supplies the round-key bus, and the block I/O.
//  It reuses sub_bytes/shift_rows/MixColumns, inv_sub_bytes/inverse_shift_rows/InvMixColumns and add_round_key.

---
 rtl/aes_iter_cipher_core.sv | 200 ++++++++++++++++++++
 tb/tb_aes_iter_cipher_core.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one full round per clock.
// Round keys come pre-expanded on the words bus; mode is latched per block.
module aes_iter_cipher_core #(
    parameter int x = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      decrypt,
    input  logic [0:127]              data_in,
    input  logic [128*(2*x+11)-1:0]   words,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:127]              data_out,
    output logic                      busy
);

    localparam logic [3:0] NR = 4'(10 + 2*x);

    typedef logic [0:15][7:0] blk_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic blk_t sub_bytes(blk_t s);
        blk_t r;
        for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
        return r;
    endfunction

    function automatic blk_t inv_sub_bytes(blk_t s);
        blk_t r;
        for (int i = 0; i < 16; i++) r[i] = INV_SBOX[s[i]];
        return r;
    endfunction

    // Byte index 4*col+row; row r rotates left by r columns.
    function automatic blk_t shift_rows(blk_t s);
        blk_t r;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                r[4*c+i] = s[4*((c+i)%4)+i];
        return r;
    endfunction

    function automatic blk_t inv_shift_rows(blk_t s);
        blk_t r;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                r[4*c+i] = s[4*((c+4-i)%4)+i];
        return r;
    endfunction

    function automatic blk_t mix_columns(blk_t s);
        blk_t r;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                r[4*c+i] = xt(s[4*c+i])
                         ^ xt(s[4*c+(i+1)%4]) ^ s[4*c+(i+1)%4]
                         ^ s[4*c+(i+2)%4]
                         ^ s[4*c+(i+3)%4];
        return r;
    endfunction

    function automatic blk_t inv_mix_columns(blk_t s);
        blk_t r;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
                r[4*c+i] = gmul(s[4*c+i], 8'h0e)
                         ^ gmul(s[4*c+(i+1)%4], 8'h0b)
                         ^ gmul(s[4*c+(i+2)%4], 8'h0d)
                         ^ gmul(s[4*c+(i+3)%4], 8'h09);
        return r;
    endfunction

    state_t     state, state_nx;
    logic [3:0] rnd;
    logic       mode;
    logic       last;
    logic [3:0] kidx;
    blk_t       st;
    blk_t       rkey;
    blk_t       enc_sr, enc_nx;
    blk_t       dec_a, dec_nx;
    blk_t       round_nx;

    assign last = (rnd == NR);

    // Before accept the key index follows the live mode input.
    always_comb begin
        kidx = '0;
        if (state == IDLE) kidx = decrypt ? NR : 4'd0;
        else               kidx = mode ? NR - rnd : rnd;
    end

    assign rkey = words[128*int'(kidx) +: 128];

    always_comb begin
        enc_sr   = shift_rows(sub_bytes(st));
        enc_nx   = (last ? enc_sr : mix_columns(enc_sr)) ^ rkey;
        dec_a    = inv_sub_bytes(inv_shift_rows(st)) ^ rkey;
        dec_nx   = last ? dec_a : inv_mix_columns(dec_a);
        round_nx = mode ? dec_nx : enc_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd      <= '0;
            mode     <= 1'b0;
            st       <= '0;
            data_out <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    mode <= decrypt;
                    st   <= data_in ^ rkey;
                    rnd  <= 4'd1;
                end
                RUN: begin
                    st <= round_nx;
                    if (last) data_out <= round_nx;
                    else      rnd      <= rnd + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher_core.sv
// Directed bench for aes_iter_cipher_core using FIPS-197 vectors
// on three instances (AES-128, AES-192, AES-256).
module tb_aes_iter_cipher_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv [3];
    logic ir [3];
    logic dm [3];
    logic ov [3];
    logic ordy [3];
    logic bsy [3];
    logic [0:127] din [3];
    logic [0:127] dout [3];
    logic [128*11-1:0] w0;
    logic [128*13-1:0] w1;
    logic [128*15-1:0] w2;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ALT  = 128'hdeadbeef0123456789abcdeffedcba98;

    always #5 clk = ~clk;

    aes_iter_cipher_core #(.x(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .decrypt(dm[0]), .data_in(din[0]), .words(w0),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .data_out(dout[0]), .busy(bsy[0])
    );

    aes_iter_cipher_core #(.x(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .decrypt(dm[1]), .data_in(din[1]), .words(w1),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .data_out(dout[1]), .busy(bsy[1])
    );

    aes_iter_cipher_core #(.x(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .decrypt(dm[2]), .data_in(din[2]), .words(w2),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .data_out(dout[2]), .busy(bsy[2])
    );

    function automatic logic [7:0] xt(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from the field inverse plus affine map, independent of any table.
    function automatic logic [7:0] sbm(logic [7:0] a);
        logic [7:0] v = '0;
        for (int b = 1; b < 256; b++)
            if (gm(a, 8'(b)) == 8'h01) v = 8'(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] t);
        return {sbm(t[31:24]), sbm(t[23:16]), sbm(t[15:8]), sbm(t[7:0])};
    endfunction

    function automatic logic [128*15-1:0] expand(logic [255:0] key, int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [128*15-1:0] r = '0;
        int nw = 4*(nk+7);
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw/4; i++)
            r[128*i +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return r;
    endfunction

    task automatic run_block(input int d, input logic m,
                             input logic [127:0] v, input logic [127:0] exp,
                             input string name);
        int cnt = 0;
        int nr = 10 + 2*d;
        while (!ir[d] && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        din[d] = v; dm[d] = m; iv[d] = 1'b1; ordy[d] = 1'b0;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        cnt = 0;
        while (!ov[d] && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        tests++;
        if (cnt !== nr) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, cnt, nr);
        end
        tests++;
        if (dout[d] !== exp) begin
            fails++;
            $display("FAIL %s data: got %h want %h", name, dout[d], exp);
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        tests++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0",
                     name, ir[d], ov[d]);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     ir[0], ov[0], bsy[0]);
        end
        tests++;
        if (dout[0] !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", dout[0]);
        end
        tests++;
        if (ir[1] !== 1'b1 || ir[2] !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_192_256: got %b %b want 1 1", ir[1], ir[2]);
        end
    endtask

    task automatic test_encrypt();
        run_block(0, 1'b0, PT, CT0, "enc128");
        run_block(1, 1'b0, PT, CT1, "enc192");
        run_block(2, 1'b0, PT, CT2, "enc256");
    endtask

    task automatic test_decrypt();
        run_block(0, 1'b1, CT0, PT, "dec128");
        run_block(1, 1'b1, CT1, PT, "dec192");
        run_block(2, 1'b1, CT2, PT, "dec256");
    endtask

    task automatic test_backpressure();
        int cnt = 0;
        din[0] = PT; dm[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        while (!ov[0] && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (ov[0] !== 1'b1 || dout[0] !== CT0 ||
                ir[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b busy=%b data=%h want 1/0/1 %h",
                         i, ov[0], ir[0], bsy[0], dout[0], CT0);
            end
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: ov=%b ir=%b busy=%b want 0/1/0",
                     ov[0], ir[0], bsy[0]);
        end
        tests++;
        if (dout[0] !== CT0) begin
            fails++;
            $display("FAIL bp_data_hold: got %h want %h", dout[0], CT0);
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt = 0;
        din[0] = PT; dm[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0 ||
            dout[0] !== 128'h0) begin
            fails++;
            $display("FAIL rst_run: ov=%b ir=%b busy=%b data=%h want 0/1/0 0",
                     ov[0], ir[0], bsy[0], dout[0]);
        end
        run_block(0, 1'b0, PT, CT0, "after_rst_run");
        din[0] = PT; dm[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        while (!ov[0] && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || dout[0] !== 128'h0) begin
            fails++;
            $display("FAIL rst_done: ov=%b ir=%b data=%h want 0/1 0",
                     ov[0], ir[0], dout[0]);
        end
        run_block(0, 1'b1, CT0, PT, "after_rst_done");
    endtask

    task automatic test_ignore_in_valid();
        int cnt = 0;
        logic bad_ready = 1'b0;
        din[0] = PT; dm[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk); #1;
        din[0] = ALT; dm[0] = 1'b1;
        while (!ov[0] && cnt < 40) begin
            if (ir[0] !== 1'b0) bad_ready = 1'b1;
            @(posedge clk); #1; cnt++;
        end
        iv[0] = 1'b0;
        tests++;
        if (cnt !== 10 || bad_ready !== 1'b0) begin
            fails++;
            $display("FAIL ignore_timing: latency %0d in_ready_seen %b want 10 0",
                     cnt, bad_ready);
        end
        tests++;
        if (dout[0] !== CT0) begin
            fails++;
            $display("FAIL ignore_data: got %h want %h", dout[0], CT0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_capture: ir=%b busy=%b want 1 0",
                     ir[0], bsy[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int cnt = 0;
        logic acc = 1'b0;
        logic pre;
        logic [127:0] got = '0;
        ordy[0] = 1'b1;
        din[0] = PT; dm[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        din[0] = CT0; dm[0] = 1'b1;
        while (!acc && k < 40) begin
            pre = ir[0];
            if (ov[0]) got = dout[0];
            @(posedge clk); #1; k++;
            if (pre) acc = 1'b1;
        end
        iv[0] = 1'b0;
        tests++;
        if (k !== 12) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d want 12", k);
        end
        tests++;
        if (got !== CT0) begin
            fails++;
            $display("FAIL b2b_enc: got %h want %h", got, CT0);
        end
        while (!ov[0] && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        tests++;
        if (cnt !== 10 || dout[0] !== PT) begin
            fails++;
            $display("FAIL b2b_dec: latency %0d data %h want 10 %h",
                     cnt, dout[0], PT);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        tests++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: ir=%b ov=%b want 1 0", ir[0], ov[0]);
        end
    endtask

    initial begin
        logic [128*15-1:0] ek;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; dm[i] = 1'b0; ordy[i] = 1'b0; din[i] = '0;
        end
        ek = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        w0 = ek[128*11-1:0];
        ek = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                     64'h0}, 6);
        w1 = ek[128*13-1:0];
        ek = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        w2 = ek;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_mid_run();
        test_ignore_in_valid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
